// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the imem/dmem memory port arbiter: FSM
//               states, port identifiers, and the pending request record.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Field widths of the request record (address, data, write size code)
    localparam int c_addr_w = 64;
    localparam int c_data_w = 64;
    localparam int c_size_w = $clog2(c_data_w / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_D = 1'b0,
        PORT_I = 1'b1
    } port_e;

    typedef struct packed {
        logic                we;
        logic [c_addr_w-1:0] addr;
        logic [c_size_w-1:0] wr_size;
        logic [c_data_w-1:0] wr_data;
    } mem_req_t;

    // Data port wins unless fetch has something and has lost too often
    function automatic port_e pick_port(input logic d_avail,
                                        input logic i_avail,
                                        input logic i_starved);
        if (i_avail && (!d_avail || i_starved)) begin
            return PORT_I;
        end
        return PORT_D;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_slot.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_slot
// Description : Single-entry pending request register for one core port.
//               Latches a request on accept, holds it until cleared at the
//               end of its completion cycle; busy mirrors occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_slot
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_accept,
    input  mem_req_t i_req,
    input  logic     i_clear,
    output logic     o_busy,
    output mem_req_t o_req
);

    logic     r_pending;
    mem_req_t r_req;

    // Occupancy and captured request; accept only ever happens while empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_req     <= '0;
        end else if (i_accept) begin
            r_pending <= 1'b1;
            r_req     <= i_req;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_busy = r_pending;
    assign o_req  = r_req;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported, variable-latency memory (req/ack)
//               between the core's fetch (imem) and data (dmem) ports. One
//               access outstanding; data port has priority, fetch is forced
//               through after STARVE_LIMIT consecutive losses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int FETCH_WIDTH  = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dmem_rd_en_i,
    input  logic                             dmem_wr_en_i,
    input  logic [DATA_WIDTH-1:0]            dmem_addr_i,
    input  logic [$clog2(FETCH_WIDTH/8)-1:0] dmem_wr_size_i,
    input  logic [FETCH_WIDTH-1:0]           dmem_wr_data_i,
    output logic                             dmem_busy_o,
    output logic                             dmem_rdy_o,
    output logic [FETCH_WIDTH-1:0]           dmem_rd_data_o,
    input  logic                             imem_rd_en_i,
    input  logic [DATA_WIDTH-1:0]            imem_addr_i,
    output logic                             imem_busy_o,
    output logic                             imem_rdy_o,
    output logic [31:0]                      imem_rd_data_o,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [DATA_WIDTH-1:0]            mem_addr_o,
    output logic [$clog2(FETCH_WIDTH/8)-1:0] mem_wr_size_o,
    output logic [FETCH_WIDTH-1:0]           mem_wr_data_o,
    input  logic                             mem_ack_i,
    input  logic [FETCH_WIDTH-1:0]           mem_rd_data_i
);

    // The request record uses the package widths, which equal the defaults
    localparam int                    c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam int                    c_WORD_W = 32;

    arb_state_e             r_state, w_state_nxt;
    port_e                  r_grant, w_grant_nxt;
    logic [c_STARVE_W-1:0]  r_starve, w_starve_nxt;

    logic                   w_d_busy, w_i_busy;
    logic                   w_d_accept, w_i_accept;
    logic                   w_d_avail, w_i_avail;
    logic                   w_d_clear, w_i_clear;
    mem_req_t               w_d_new, w_i_new;
    mem_req_t               w_d_req, w_i_req, w_sel;

    logic [FETCH_WIDTH-1:0] r_dmem_rd_data;
    logic [c_WORD_W-1:0]    r_imem_rd_data;

    // A write wins over a simultaneous read; fetches never write
    always_comb begin
        w_d_new         = '0;
        w_d_new.we      = dmem_wr_en_i;
        w_d_new.addr    = dmem_addr_i;
        w_d_new.wr_size = dmem_wr_size_i;
        w_d_new.wr_data = dmem_wr_data_i;
        w_i_new         = '0;
        w_i_new.addr    = imem_addr_i;
    end

    // Enables are only taken while the port's slot is empty
    assign w_d_accept = (dmem_rd_en_i | dmem_wr_en_i) & ~w_d_busy;
    assign w_i_accept = imem_rd_en_i & ~w_i_busy;

    // A request being accepted this cycle competes immediately
    assign w_d_avail = w_d_busy | w_d_accept;
    assign w_i_avail = w_i_busy | w_i_accept;

    assign w_d_clear = (r_state == RESP) && (r_grant == PORT_D);
    assign w_i_clear = (r_state == RESP) && (r_grant == PORT_I);

    mem_req_slot u_slot_d (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_d_accept),
        .i_req    (w_d_new),
        .i_clear  (w_d_clear),
        .o_busy   (w_d_busy),
        .o_req    (w_d_req)
    );

    mem_req_slot u_slot_i (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_i_accept),
        .i_req    (w_i_new),
        .i_clear  (w_i_clear),
        .o_busy   (w_i_busy),
        .o_req    (w_i_req)
    );

    // State, grant and starvation count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= PORT_D;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Arbitrate in IDLE, wait for ack in ISSUE, pulse completion in RESP
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_starve_nxt = r_starve;
        unique case (r_state)
            IDLE: begin
                if (w_d_avail || w_i_avail) begin
                    w_state_nxt = ISSUE;
                    w_grant_nxt = pick_port(w_d_avail, w_i_avail,
                                            r_starve == c_STARVE_MAX);
                    if (w_grant_nxt == PORT_I) begin
                        w_starve_nxt = '0;
                    end else if (w_i_avail) begin
                        w_starve_nxt = r_starve + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack_i) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture read data with the ack; writes leave dmem read data untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dmem_rd_data <= '0;
            r_imem_rd_data <= '0;
        end else if ((r_state == ISSUE) && mem_ack_i) begin
            if (r_grant == PORT_I) begin
                r_imem_rd_data <= w_sel.addr[2] ? mem_rd_data_i[2*c_WORD_W-1:c_WORD_W]
                                                : mem_rd_data_i[c_WORD_W-1:0];
            end else if (!w_sel.we) begin
                r_dmem_rd_data <= mem_rd_data_i;
            end
        end
    end

    // Memory side presents the granted slot only while a request is open
    assign w_sel         = (r_grant == PORT_I) ? w_i_req : w_d_req;
    assign mem_req_o     = (r_state == ISSUE);
    assign mem_we_o      = mem_req_o & w_sel.we;
    assign mem_addr_o    = mem_req_o ? w_sel.addr    : '0;
    assign mem_wr_size_o = mem_req_o ? w_sel.wr_size : '0;
    assign mem_wr_data_o = mem_req_o ? w_sel.wr_data : '0;

    assign dmem_busy_o    = w_d_busy;
    assign imem_busy_o    = w_i_busy;
    assign dmem_rdy_o     = w_d_clear;
    assign imem_rdy_o     = w_i_clear;
    assign dmem_rd_data_o = r_dmem_rd_data;
    assign imem_rd_data_o = r_imem_rd_data;

endmodule
`default_nettype wire
